// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and elaboration helpers for the pipelined ripple-carry adder
package adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // Bit positions of the per-stage control word carried next to the datapath.
  localparam int CTRL_VALID = 0;
  localparam int CTRL_CARRY = 1;
  localparam int CTRL_AMSB  = 2;
  localparam int CTRL_BMSB  = 3;
  localparam int CTRL_BITS  = 4;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // The operand must split into equal, non-empty chunks.
  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/fullAdder.sv
// rtl/fullAdder.sv - single-bit full adder cell
module fullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational ripple-carry adder over one CHUNK-bit slice
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = ci_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fullAdder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (carry[i]),
      .s_o  (s_o[i]),
      .co_o (carry[i+1])
    );
  end

  assign co_o = carry[CHUNK];

endmodule

// File: rtl/rca_pipe_adder.sv
// rtl/rca_pipe_adder.sv - pipelined ripple-carry adder/subtractor with valid/ready on both sides
module rca_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("rca_pipe_adder: WIDTH must split into STAGES equal chunks");
  end

  // Stage k registers: full operands (upper chunks still needed downstream),
  // partial sum (chunks 0..k filled), and the control word.
  logic [WIDTH-1:0]     a_q    [STAGES];
  logic [WIDTH-1:0]     b_q    [STAGES];
  logic [WIDTH-1:0]     s_q    [STAGES];
  logic [CTRL_BITS-1:0] ctrl_q [STAGES];

  // Stage k inputs (from the ports for stage 0, from stage k-1 otherwise).
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] am_in;
  logic [STAGES-1:0] bm_in;
  logic [STAGES-1:0] co_d;

  logic advance;

  // The whole pipe moves as one; it stalls only when a finished result is unclaimed.
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] chunk_sum;

    if (k == 0) begin : g_entry
      // Subtraction is a + ~b + 1; cin only matters for addition.
      assign a_in[0]  = a;
      assign b_in[0]  = b ^ {WIDTH{sub}};
      assign s_in[0]  = '0;
      assign c_in[0]  = sub | cin;
      assign v_in[0]  = in_valid;
      assign am_in[0] = a[WIDTH-1];
      assign bm_in[0] = b[WIDTH-1] ^ sub;
    end else begin : g_link
      assign a_in[k]  = a_q[k-1];
      assign b_in[k]  = b_q[k-1];
      assign s_in[k]  = s_q[k-1];
      assign c_in[k]  = ctrl_q[k-1][CTRL_CARRY];
      assign v_in[k]  = ctrl_q[k-1][CTRL_VALID];
      assign am_in[k] = ctrl_q[k-1][CTRL_AMSB];
      assign bm_in[k] = ctrl_q[k-1][CTRL_BMSB];
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i  (a_in[k][k*CHUNK +: CHUNK]),
      .b_i  (b_in[k][k*CHUNK +: CHUNK]),
      .ci_i (c_in[k]),
      .s_o  (chunk_sum),
      .co_o (co_d[k])
    );

    // Chunk k of the incoming partial sum is still zero, so OR-ing merges it in.
    assign s_d[k] = s_in[k] | (WIDTH'(chunk_sum) << (k * CHUNK));
  end

  // Pipeline registers: cleared on reset, shifted together on advance, held on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        s_q[k]    <= '0;
        ctrl_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]                <= a_in[k];
        b_q[k]                <= b_in[k];
        s_q[k]                <= s_d[k];
        ctrl_q[k][CTRL_VALID] <= v_in[k];
        ctrl_q[k][CTRL_CARRY] <= co_d[k];
        ctrl_q[k][CTRL_AMSB]  <= am_in[k];
        ctrl_q[k][CTRL_BMSB]  <= bm_in[k];
      end
    end
  end

  assign sum       = s_q[STAGES-1];
  assign cout      = ctrl_q[STAGES-1][CTRL_CARRY];
  assign out_valid = ctrl_q[STAGES-1][CTRL_VALID];
  assign ovf       = (ctrl_q[STAGES-1][CTRL_AMSB] == ctrl_q[STAGES-1][CTRL_BMSB]) &
                     (sum[WIDTH-1] != ctrl_q[STAGES-1][CTRL_AMSB]);

endmodule

// File: tb/tb_rca_pipe_adder.sv
// tb/tb_rca_pipe_adder.sv - scoreboard testbench for rca_pipe_adder
module tb_rca_pipe_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         rdy4, ov4, cout4, ovf4;
  logic [W-1:0] sum4;
  logic         rdy1, ov1, cout1, ovf1;
  logic [W-1:0] sum1;
  logic         rdy32, ov32, cout32, ovf32;
  logic [W-1:0] sum32;

  int errors = 0;
  int checks = 0;

  logic [W+1:0] sb_q[$];

  always #5 clk = ~clk;

  rca_pipe_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(out_ready),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  rca_pipe_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  rca_pipe_adder #(.WIDTH(W), .STAGES(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  // Reference: {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W:0]   t;
    logic [W-1:0] s;
    logic         c;
    logic         o;
    if (sb) t = {1'b0, x} - {1'b0, y};
    else    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    s = t[W-1:0];
    c = sb ? ~t[W] : t[W];
    if (sb) o = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    else    o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {o, c, s};
  endfunction

  // One clock: record input handshake into the scoreboard, collect an output handshake.
  task automatic cycle(output bit got_v, output logic [W+1:0] got, output logic [W+1:0] exp);
    got_v = 1'b0;
    got   = '0;
    exp   = '0;
    if (in_valid && rdy4) sb_q.push_back(model(a, b, cin, sub));
    if (ov4 && out_ready) begin
      got_v = 1'b1;
      got   = {ovf4, cout4, sum4};
      if (sb_q.size() > 0) exp = sb_q.pop_front();
      else                 exp = 'x;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ov4 !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov4); end
    checks++; if (sum4 !== '0)   begin errors++; $display("FAIL reset_sum got=%h exp=0", sum4); end
    checks++; if (cout4 !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout4); end
    checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf4); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", rdy4); end
    checks++; if ({ov1, ov32} !== 2'b00) begin errors++; $display("FAIL reset_variants_valid got=%b exp=00", {ov1, ov32}); end
  endtask

  task automatic test_carry_ripple();
    bit           gv;
    logic [W+1:0] g, e;
    int           lat;
    lat = -1;
    a = 32'h0000_0001; b = 32'hFFFF_FFFF; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle(gv, g, e);
    in_valid = 1'b0;
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      cycle(gv, g, e);
      if (gv) begin
        lat = n;
        checks++; if (g !== e) begin errors++; $display("FAIL ripple_model got=%h exp=%h", g, e); end
        checks++; if (g !== {1'b0, 1'b1, 32'h0000_0000}) begin errors++; $display("FAIL ripple_const got=%h exp=%h", g, {1'b0, 1'b1, 32'h0}); end
      end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_ovf_and_sub();
    bit           gv, hs;
    logic [W+1:0] g, e;
    logic [W+1:0] kexp [2];
    logic [W-1:0] ta   [2];
    logic [W-1:0] tb   [2];
    logic         ts   [2];
    int           i, got_n;
    kexp[0] = {1'b1, 1'b0, 32'h8000_0000};
    kexp[1] = {1'b0, 1'b0, 32'hFFFF_FFFE};
    ta[0] = 32'h7FFF_FFFF; tb[0] = 32'h1; ts[0] = 1'b0;
    ta[1] = 32'h5;         tb[1] = 32'h7; ts[1] = 1'b1;
    i = 0; got_n = 0; out_ready = 1'b1; cin = 1'b0;
    for (int n = 0; n < 20 && got_n < 2; n++) begin
      in_valid = (i < 2);
      if (i < 2) begin a = ta[i]; b = tb[i]; sub = ts[i]; end
      hs = in_valid && rdy4;
      cycle(gv, g, e);
      if (hs) i++;
      if (gv) begin
        checks++; if (g !== e) begin errors++; $display("FAIL ovfsub_model_%0d got=%h exp=%h", got_n, g, e); end
        checks++; if (g !== kexp[got_n]) begin errors++; $display("FAIL ovfsub_const_%0d got=%h exp=%h", got_n, g, kexp[got_n]); end
        got_n++;
      end
    end
    in_valid = 1'b0; sub = 1'b0;
    checks++; if (got_n !== 2) begin errors++; $display("FAIL ovfsub_count got=%0d exp=2", got_n); end
  endtask

  task automatic test_back_to_back();
    bit           gv, hs;
    logic [W+1:0] g, e;
    int           i, got_n, first;
    i = 0; got_n = 0; first = -1; out_ready = 1'b1;
    for (int n = 0; n < 60 && got_n < 16; n++) begin
      in_valid = (i < 16);
      if (i < 16) begin
        a = $urandom; b = $urandom;
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready n=%0d got=%b exp=1", n, rdy4); end
      end
      hs = in_valid && rdy4;
      cycle(gv, g, e);
      if (hs) i++;
      if (gv) begin
        if (first < 0) first = n;
        checks++; if (g !== e) begin errors++; $display("FAIL b2b_result_%0d got=%h exp=%h", got_n, g, e); end
        checks++; if (n !== first + got_n) begin errors++; $display("FAIL b2b_cadence_%0d got=%0d exp=%0d", got_n, n, first + got_n); end
        got_n++;
      end
    end
    in_valid = 1'b0;
    checks++; if (first !== 4) begin errors++; $display("FAIL b2b_first_cycle got=%0d exp=4", first); end
    checks++; if (got_n !== 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", got_n); end
  endtask

  task automatic test_stall();
    bit           gv, hs;
    logic [W+1:0] g, e;
    logic [W+2:0] snap;
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    logic         tc [6];
    logic         ts [6];
    int           i, got_n, extra;
    for (int k = 0; k < 6; k++) begin
      ta[k] = $urandom; tb[k] = $urandom;
      tc[k] = 1'($urandom_range(0, 1)); ts[k] = 1'($urandom_range(0, 1));
    end
    i = 0; got_n = 0; extra = 0; snap = '0;
    for (int n = 0; n < 60 && got_n < 6; n++) begin
      out_ready = !(n >= 5 && n < 10);
      in_valid  = (i < 6);
      if (i < 6) begin a = ta[i]; b = tb[i]; cin = tc[i]; sub = ts[i]; end
      #1;
      if (n >= 5 && n < 10) begin
        checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL stall_in_ready n=%0d got=%b exp=0", n, rdy4); end
        if (n == 5) snap = {ov4, ovf4, cout4, sum4};
        checks++; if ({ov4, ovf4, cout4, sum4} !== snap || ov4 !== 1'b1) begin
          errors++; $display("FAIL stall_frozen n=%0d got=%h exp=%h", n, {ov4, ovf4, cout4, sum4}, snap);
        end
      end
      hs = in_valid && rdy4;
      cycle(gv, g, e);
      if (hs) i++;
      if (gv) begin
        checks++; if (g !== e) begin errors++; $display("FAIL stall_result_%0d got=%h exp=%h", got_n, g, e); end
        got_n++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
    for (int n = 0; n < 6; n++) begin
      cycle(gv, g, e);
      if (gv) extra++;
    end
    checks++; if (got_n !== 6) begin errors++; $display("FAIL stall_count got=%0d exp=6", got_n); end
    checks++; if (extra !== 0 || sb_q.size() !== 0) begin errors++; $display("FAIL stall_exactly_once extra=%0d pending=%0d exp=0", extra, sb_q.size()); end
  endtask

  task automatic test_reset_midflight();
    bit           gv;
    logic [W+1:0] g, e;
    int           leaked;
    leaked = 0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    for (int n = 0; n < 4; n++) begin
      in_valid = (n < 3);
      a = 32'h1000_0000 + n; b = 32'h0000_0101;
      cycle(gv, g, e);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%b exp=1", ov4); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", ov4); end
    checks++; if (sum4 !== '0)  begin errors++; $display("FAIL midrst_sum got=%h exp=0", sum4); end
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      cycle(gv, g, e);
      if (gv) leaked++;
    end
    checks++; if (leaked !== 0) begin errors++; $display("FAIL midrst_leaked got=%0d exp=0", leaked); end
  endtask

  task automatic test_stage_variants();
    bit           gv;
    logic [W+1:0] g, e;
    int           lat1, lat32;
    do_reset();
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if ({rdy1, rdy32} !== 2'b11) begin errors++; $display("FAIL variants_in_ready got=%b exp=11", {rdy1, rdy32}); end
    cycle(gv, g, e);
    in_valid = 1'b0;
    lat1 = -1; lat32 = -1;
    for (int n = 1; n <= 40 && lat32 < 0; n++) begin
      if (ov1 && lat1 < 0) begin
        lat1 = n;
        checks++; if ({cout1, sum1} !== {1'b0, 32'hF0E2_1568}) begin errors++; $display("FAIL s1_result got=%h exp=%h", {cout1, sum1}, {1'b0, 32'hF0E2_1568}); end
      end
      if (ov32 && lat32 < 0) begin
        lat32 = n;
        checks++; if ({cout32, sum32} !== {1'b0, 32'hF0E2_1568}) begin errors++; $display("FAIL s32_result got=%h exp=%h", {cout32, sum32}, {1'b0, 32'hF0E2_1568}); end
      end
      cycle(gv, g, e);
      if (gv) begin
        checks++; if (g !== e) begin errors++; $display("FAIL s4_result got=%h exp=%h", g, e); end
      end
    end
    checks++; if (lat1 !== 1)   begin errors++; $display("FAIL s1_latency got=%0d exp=1", lat1); end
    checks++; if (lat32 !== 32) begin errors++; $display("FAIL s32_latency got=%0d exp=32", lat32); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_carry_ripple();
    test_ovf_and_sub();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_stage_variants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
